// File: rtl/mult_scheduler.sv
// Round-robin scheduler that time-shares one start/finish multiplier among NUM_REQ clients.
// With CONST_TIME set, every grant occupies a fixed-length slot, so latency does not depend on operand values.
//   state   | meaning
//   IDLE    | no grant outstanding, arbitrating on req
//   ISSUE   | operands latched, mult_start pulsed
//   WAIT    | multiply in flight, capturing mult_finish
//   RELEASE | done pulse to owner; may re-arbitrate at the closing edge
module mult_scheduler #(
    parameter int WIDTH       = 8,
    parameter int NUM_REQ     = 3,
    parameter int CONST_TIME  = 1,
    parameter int SLOT_CYCLES = 2*WIDTH+4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   in1_bus,
    input  logic [NUM_REQ*WIDTH-1:0]   in2_bus,
    output logic [NUM_REQ-1:0]         ack,
    output logic [NUM_REQ-1:0]         done,
    output logic [2*WIDTH-1:0]         out,
    output logic                       busy,
    output logic                       overrun,
    output logic                       mult_start,
    output logic [WIDTH-1:0]           mult_in1,
    output logic [WIDTH-1:0]           mult_in2,
    input  logic [2*WIDTH-1:0]         mult_out,
    input  logic                       mult_finish
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES+1) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

    state_t             state;
    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      owner;
    logic [IW-1:0]      winner;
    logic [IW-1:0]      sel;
    logic               found;
    int                 idx;
    logic [CW-1:0]      cnt;
    logic               got;
    logic [2*WIDTH-1:0] result;
    logic               slot_end;
    logic               got_final;
    logic [2*WIDTH-1:0] result_final;

    // Scan starting just after the last winner so the previous owner goes last.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        sel    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            sel = IW'(idx);
            if (!found && req[sel]) begin
                winner = sel;
                found  = 1'b1;
            end
        end
    end

    // A finish arriving in the slot's last cycle still counts.
    always_comb begin
        got_final    = got | mult_finish;
        result_final = mult_finish ? mult_out : result;
        slot_end     = (CONST_TIME != 0) ? (cnt == CW'(SLOT_CYCLES-1)) : got;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= IW'(NUM_REQ-1);
            owner      <= '0;
            cnt        <= '0;
            got        <= 1'b0;
            result     <= '0;
            ack        <= '0;
            done       <= '0;
            out        <= '0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            mult_start <= 1'b0;
            mult_in1   <= '0;
            mult_in2   <= '0;
        end else begin
            ack        <= '0;
            done       <= '0;
            mult_start <= 1'b0;
            case (state)
                IDLE, RELEASE: begin
                    if (found) begin
                        mult_in1   <= in1_bus[winner*WIDTH +: WIDTH];
                        mult_in2   <= in2_bus[winner*WIDTH +: WIDTH];
                        owner      <= winner;
                        rr_ptr     <= winner;
                        ack        <= NUM_REQ'(1) << winner;
                        mult_start <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    got   <= 1'b0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (mult_finish) begin
                        result <= mult_out;
                        got    <= 1'b1;
                    end
                    if (CONST_TIME != 0) cnt <= cnt + CW'(1);
                    if (slot_end) begin
                        done  <= NUM_REQ'(1) << owner;
                        state <= RELEASE;
                        if ((CONST_TIME != 0) && !got_final) begin
                            out     <= '0;
                            overrun <= 1'b1;
                        end else begin
                            out <= result_final;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
